// File: rtl/mdu_ctrl_pkg.sv
// Shared funct codes and sequencer state encoding for the multiply/divide unit.
package mdu_ctrl_pkg;

    localparam logic [5:0] EXE_MULT  = 6'b011000;
    localparam logic [5:0] EXE_MULTU = 6'b011001;
    localparam logic [5:0] EXE_DIV   = 6'b011010;
    localparam logic [5:0] EXE_DIVU  = 6'b011011;
    localparam logic [5:0] EXE_MTHI  = 6'b010001;
    localparam logic [5:0] EXE_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl_div_core.sv
// Radix-2 restoring divider datapath: one unsigned subtract-and-shift per step.
module div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH+1:0] trial;

    // Two guard bits: the shifted partial remainder can reach 2^(WIDTH+1)-1.
    assign trial = {1'b0, rem_q, quo_q[WIDTH-1]} - {2'b00, div_q};

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        div_d = div_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            div_d = divisor_i;
        end else if (step_i) begin
            if (trial[WIDTH+1]) begin
                rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end else begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            div_q <= div_d;
        end
    end

    assign quo_o = quo_q;
    assign rem_o = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer owning HI/LO; stalls the pipe during a divide.
// Optional MDU_EARLY_ZERO_EN: a divide by zero skips the iteration phase.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [5:0]       alucontrol,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    mdu_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic             qsign_q, qsign_d, rsign_q, rsign_d, zero_q, zero_d;

    logic             go, is_div, is_mul, is_signed, load, step;
    logic [WIDTH-1:0] mag_a, mag_b, quo, rem;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;

    assign go        = valid_i & ~flush_i & (state_q == MDU_IDLE);
    assign is_div    = (alucontrol == EXE_DIV) | (alucontrol == EXE_DIVU);
    assign is_mul    = (alucontrol == EXE_MULT) | (alucontrol == EXE_MULTU);
    assign is_signed = (alucontrol == EXE_DIV) | (alucontrol == EXE_MULT);

    assign mag_a = (is_signed & a_i[WIDTH-1]) ? -a_i : a_i;
    assign mag_b = (is_signed & b_i[WIDTH-1]) ? -b_i : b_i;

    // Sign-extending to 2*WIDTH makes one unsigned multiply serve both flavours.
    assign ext_a = {{WIDTH{is_signed & a_i[WIDTH-1]}}, a_i};
    assign ext_b = {{WIDTH{is_signed & b_i[WIDTH-1]}}, b_i};
    assign prod  = ext_a * ext_b;

    div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .step_i    (step),
        .dividend_i(mag_a),
        .divisor_i (mag_b),
        .quo_o     (quo),
        .rem_o     (rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        araw_d  = araw_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        zero_d  = zero_q;
        load    = 1'b0;
        step    = 1'b0;
        stall_o = 1'b0;
        unique case (state_q)
            MDU_IDLE: begin
                if (go && is_div) begin
                    load    = 1'b1;
                    stall_o = 1'b1;
                    cnt_d   = '0;
                    araw_d  = a_i;
                    qsign_d = is_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    rsign_d = is_signed & a_i[WIDTH-1];
                    zero_d  = (b_i == '0);
`ifdef MDU_EARLY_ZERO_EN
                    state_d = (b_i == '0) ? MDU_DONE : MDU_RUN;
`else
                    state_d = MDU_RUN;
`endif
                end else if (go && is_mul) begin
                    {hi_d, lo_d} = prod;
                end else if (go && alucontrol == EXE_MTHI) begin
                    hi_d = a_i;
                end else if (go && alucontrol == EXE_MTLO) begin
                    lo_d = a_i;
                end
            end
            MDU_RUN: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                end else begin
                    step = 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = MDU_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
                if (!flush_i) begin
                    if (zero_q) begin
                        hi_d = araw_q;
                        lo_d = '1;
                    end else begin
                        lo_d = qsign_q ? -quo : quo;
                        hi_d = rsign_q ? -rem : rem;
                    end
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            araw_q  <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            araw_q  <= araw_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            zero_q  <= zero_d;
        end
    end

    assign busy_o = (state_q != MDU_IDLE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
